// File: rtl/frogger_game_sequencer_pkg.sv
// rtl/frogger_game_sequencer_pkg.sv - shared state codes, tile codes and helpers for the Frogger game sequencer
package frogger_game_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PLAYING   = 3'd1,
        ST_DYING     = 3'd2,
        ST_SCORED    = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_e;

    localparam logic [3:0] TILE_WALL  = 4'd0;
    localparam logic [3:0] TILE_ROAD  = 4'd1;
    localparam logic [3:0] TILE_WATER = 4'd2;
    localparam logic [3:0] TILE_SAFE  = 4'd3;
    localparam logic [3:0] TILE_LILY  = 4'd4;

    localparam int unsigned GAME_WIDTH  = 20;
    localparam int unsigned GAME_HEIGHT = 15;

    localparam logic [2:0] LEVEL_MAX = 3'd7;

    function automatic logic [6:0] sat_inc7(input logic [6:0] v, input logic [6:0] max_v);
        return (v >= max_v) ? max_v : v + 7'd1;
    endfunction

endpackage

// File: rtl/frogger_game_sequencer_if.sv
// rtl/frogger_game_sequencer_if.sv - game sequencer input/output bundle
interface frogger_game_sequencer_if;
    logic       i_VSync;
    logic       i_Game_Start;
    logic       i_Collided;
    logic [5:0] i_Frogger_Y;
    logic [3:0] i_Tile_Data;
    logic       o_Move_Enable;
    logic       o_Respawn;
    logic       o_Game_Active;
    logic       o_Flash;
    logic [1:0] o_Lives;
    logic [6:0] o_Score;
    logic [2:0] o_Level;
    logic [2:0] o_State;

    modport master (
        output i_VSync, i_Game_Start, i_Collided, i_Frogger_Y, i_Tile_Data,
        input  o_Move_Enable, o_Respawn, o_Game_Active, o_Flash,
               o_Lives, o_Score, o_Level, o_State
    );

    modport slave (
        input  i_VSync, i_Game_Start, i_Collided, i_Frogger_Y, i_Tile_Data,
        output o_Move_Enable, o_Respawn, o_Game_Active, o_Flash,
               o_Lives, o_Score, o_Level, o_State
    );
endinterface

// File: rtl/frogger_game_sequencer_edge_rise_det.sv
// rtl/frogger_game_sequencer_edge_rise_det.sv - two-flop rising-edge pulse generator
module edge_rise_det (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Sig,
    output logic o_Pulse
);
    logic sig_q;
    logic prev_q;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sig_q  <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            sig_q  <= i_Sig;
            prev_q <= sig_q;
        end
    end

    // Pulse is one cycle wide, the cycle after the input was first sampled high.
    assign o_Pulse = sig_q & ~prev_q;
endmodule

// File: rtl/frogger_game_sequencer.sv
// rtl/frogger_game_sequencer.sv - Frogger round sequencer: lives, score, level, respawn and move gating
module frogger_game_sequencer
    import frogger_game_sequencer_pkg::*;
#(
    parameter int unsigned c_LIVES        = 3,
    parameter int unsigned c_DEATH_FRAMES = 60,
    parameter int unsigned c_SCORE_FRAMES = 30,
    parameter int unsigned c_FLASH_FRAMES = 8,
    parameter int unsigned c_MAX_SCORE    = 99,
    parameter int unsigned c_HOME_ROW     = 0,
    parameter int unsigned c_WATER_TILE   = 2
) (
    input  logic                        i_Clk,
    input  logic                        i_Rst_L,
    frogger_game_sequencer_if.slave     bus
);
    localparam logic [1:0] LIVES_INIT   = 2'(c_LIVES);
    localparam logic [7:0] DEATH_FRAMES = 8'(c_DEATH_FRAMES);
    localparam logic [7:0] SCORE_FRAMES = 8'(c_SCORE_FRAMES);
    localparam logic [7:0] FLASH_FRAMES = 8'(c_FLASH_FRAMES);
    localparam logic [6:0] MAX_SCORE    = 7'(c_MAX_SCORE);
    localparam logic [5:0] HOME_ROW     = 6'(c_HOME_ROW);
    localparam logic [3:0] WATER_TILE   = 4'(c_WATER_TILE);

    logic tick;
    logic press;

    edge_rise_det u_vsync_edge (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .i_Sig   (bus.i_VSync),
        .o_Pulse (tick)
    );

    edge_rise_det u_start_edge (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .i_Sig   (bus.i_Game_Start),
        .o_Pulse (press)
    );

    state_e     state_q;
    logic [1:0] lives_q;
    logic [6:0] score_q;
    logic [2:0] level_q;
    logic       move_en_q;
    logic       respawn_q;
    logic       active_q;
    logic       flash_q;
    logic [7:0] frame_cnt_q;
    logic [7:0] flash_cnt_q;

    logic       hazard;
    logic       at_home;
    logic [7:0] frame_next;
    logic [7:0] flash_next;

    assign hazard     = bus.i_Collided | (bus.i_Tile_Data == WATER_TILE);
    assign at_home    = (bus.i_Frogger_Y == HOME_ROW);
    assign frame_next = frame_cnt_q + 8'd1;
    assign flash_next = flash_cnt_q + 8'd1;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q     <= ST_IDLE;
            lives_q     <= 2'd0;
            score_q     <= 7'd0;
            level_q     <= 3'd0;
            move_en_q   <= 1'b0;
            respawn_q   <= 1'b0;
            active_q    <= 1'b0;
            flash_q     <= 1'b0;
            frame_cnt_q <= 8'd0;
            flash_cnt_q <= 8'd0;
        end else begin
            respawn_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_GAME_OVER: begin
                    flash_q <= 1'b0;
                    if (press) begin
                        state_q   <= ST_PLAYING;
                        lives_q   <= LIVES_INIT;
                        score_q   <= 7'd0;
                        level_q   <= 3'd0;
                        respawn_q <= 1'b1;
                        move_en_q <= 1'b1;
                        active_q  <= 1'b1;
                    end else begin
                        move_en_q <= 1'b0;
                        active_q  <= 1'b0;
                    end
                end
                ST_PLAYING: begin
                    // A frog that lands on the home row while dying still dies.
                    if (hazard) begin
                        state_q     <= ST_DYING;
                        frame_cnt_q <= 8'd0;
                        flash_cnt_q <= 8'd0;
                        flash_q     <= 1'b1;
                        move_en_q   <= 1'b0;
                    end else if (at_home) begin
                        state_q     <= ST_SCORED;
                        frame_cnt_q <= 8'd0;
                        score_q     <= sat_inc7(score_q, MAX_SCORE);
                        level_q     <= (level_q == LEVEL_MAX) ? LEVEL_MAX : level_q + 3'd1;
                        move_en_q   <= 1'b0;
                    end
                end
                ST_DYING: begin
                    if (tick) begin
                        if (frame_next == DEATH_FRAMES) begin
                            frame_cnt_q <= 8'd0;
                            flash_q     <= 1'b0;
                            if (lives_q != 2'd0) begin
                                lives_q <= lives_q - 2'd1;
                            end
                            if (lives_q <= 2'd1) begin
                                state_q  <= ST_GAME_OVER;
                                active_q <= 1'b0;
                            end else begin
                                state_q   <= ST_PLAYING;
                                respawn_q <= 1'b1;
                                move_en_q <= 1'b1;
                            end
                        end else begin
                            frame_cnt_q <= frame_next;
                            if (flash_next == FLASH_FRAMES) begin
                                flash_cnt_q <= 8'd0;
                                flash_q     <= ~flash_q;
                            end else begin
                                flash_cnt_q <= flash_next;
                            end
                        end
                    end
                end
                ST_SCORED: begin
                    if (tick) begin
                        if (frame_next == SCORE_FRAMES) begin
                            frame_cnt_q <= 8'd0;
                            state_q     <= ST_PLAYING;
                            respawn_q   <= 1'b1;
                            move_en_q   <= 1'b1;
                        end else begin
                            frame_cnt_q <= frame_next;
                        end
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    move_en_q <= 1'b0;
                    active_q  <= 1'b0;
                    flash_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_Move_Enable = move_en_q;
    assign bus.o_Respawn     = respawn_q;
    assign bus.o_Game_Active = active_q;
    assign bus.o_Flash       = flash_q;
    assign bus.o_Lives       = lives_q;
    assign bus.o_Score       = score_q;
    assign bus.o_Level       = level_q;
    assign bus.o_State       = state_q;
endmodule

// File: tb/tb_frogger_game_sequencer.sv
// tb/tb_frogger_game_sequencer.sv - self-checking bench for frogger_game_sequencer
module tb_frogger_game_sequencer;

    localparam int S_IDLE = 0, S_PLAYING = 1, S_DYING = 2, S_SCORED = 3, S_GAME_OVER = 4;
    localparam int LIVES = 3, DEATH_FR = 60, SCORE_FR = 30, FLASH_FR = 8, MAX_SCORE = 99;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fails  = 0;
    int   m_lives, m_score, m_level;

    frogger_game_sequencer_if bus();

    frogger_game_sequencer dut (
        .i_Clk   (clk),
        .i_Rst_L (rst_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Frog somewhere mid-field on a tile that neither kills nor scores.
    task automatic benign();
        int t;
        t = $urandom_range(0, 3);
        bus.i_Collided  = 1'b0;
        bus.i_Frogger_Y = 6'($urandom_range(1, 14));
        bus.i_Tile_Data = 4'((t >= 2) ? t + 1 : t);
    endtask

    task automatic tick(output int rs);
        rs = 0;
        bus.i_VSync = 1'b1;
        repeat (2) begin @(negedge clk); if (bus.o_Respawn === 1'b1) rs++; end
        bus.i_VSync = 1'b0;
        repeat (3) begin @(negedge clk); if (bus.o_Respawn === 1'b1) rs++; end
    endtask

    task automatic press(output int rs);
        rs = 0;
        bus.i_Game_Start = 1'b1;
        repeat (2) begin @(negedge clk); if (bus.o_Respawn === 1'b1) rs++; end
        bus.i_Game_Start = 1'b0;
        repeat (4) begin @(negedge clk); if (bus.o_Respawn === 1'b1) rs++; end
    endtask

    task automatic start_game(input string tag);
        int r;
        press(r);
        m_lives = LIVES; m_score = 0; m_level = 0;
        chk({tag, "_respawn_cycles"}, r, 1);
        chk({tag, "_state"}, bus.o_State, S_PLAYING);
        chk({tag, "_lives"}, bus.o_Lives, m_lives);
        chk({tag, "_score"}, bus.o_Score, 0);
        chk({tag, "_level"}, bus.o_Level, 0);
        chk({tag, "_move_en"}, bus.o_Move_Enable, 1);
        chk({tag, "_active"}, bus.o_Game_Active, 1);
    endtask

    task automatic die(input bit water, input bit also_home, input bit press_mid);
        int r, rs;
        rs = 0;
        if (water) bus.i_Tile_Data = 4'd2; else bus.i_Collided = 1'b1;
        if (also_home) bus.i_Frogger_Y = 6'd0;
        @(negedge clk);
        benign();
        chk("die_entry_state", bus.o_State, S_DYING);
        chk("die_entry_flash", bus.o_Flash, 1);
        chk("die_entry_move", bus.o_Move_Enable, 0);
        chk("die_entry_score", bus.o_Score, m_score);
        for (int k = 1; k <= DEATH_FR; k++) begin
            tick(r); rs += r;
            if (press_mid && k == 20) begin press(r); rs += r; end
            if (k < DEATH_FR) begin
                chk("die_state", bus.o_State, S_DYING);
                chk("die_flash", bus.o_Flash, ((k / FLASH_FR) % 2 == 0) ? 1 : 0);
            end
        end
        m_lives--;
        chk("die_lives", bus.o_Lives, m_lives);
        chk("die_flash_exit", bus.o_Flash, 0);
        chk("die_exit_state", bus.o_State, (m_lives == 0) ? S_GAME_OVER : S_PLAYING);
        chk("die_respawns", rs, (m_lives == 0) ? 0 : 1);
        chk("die_move", bus.o_Move_Enable, (m_lives == 0) ? 0 : 1);
        chk("die_active", bus.o_Game_Active, (m_lives == 0) ? 0 : 1);
        chk("die_score_held", bus.o_Score, m_score);
    endtask

    task automatic goal(input bit press_mid);
        int r, rs;
        rs = 0;
        bus.i_Frogger_Y = 6'd0;
        @(negedge clk);
        benign();
        m_score = (m_score + 1 > MAX_SCORE) ? MAX_SCORE : m_score + 1;
        m_level = (m_level + 1 > 7) ? 7 : m_level + 1;
        chk("goal_state", bus.o_State, S_SCORED);
        chk("goal_score", bus.o_Score, m_score);
        chk("goal_level", bus.o_Level, m_level);
        chk("goal_move", bus.o_Move_Enable, 0);
        for (int k = 1; k <= SCORE_FR; k++) begin
            tick(r); rs += r;
            if (press_mid && k == 10) begin
                press(r); rs += r;
                chk("goal_press_ignored", bus.o_State, S_SCORED);
            end
            if (k == SCORE_FR - 1) chk("goal_still_scored", bus.o_State, S_SCORED);
        end
        chk("goal_exit_state", bus.o_State, S_PLAYING);
        chk("goal_respawns", rs, 1);
        chk("goal_move_exit", bus.o_Move_Enable, 1);
        chk("goal_score_after", bus.o_Score, m_score);
        chk("goal_lives_after", bus.o_Lives, m_lives);
    endtask

    initial begin
        int r;
        bus.i_VSync = 1'b0;
        bus.i_Game_Start = 1'b0;
        benign();
        repeat (3) @(negedge clk);
        chk("rst_state", bus.o_State, S_IDLE);
        chk("rst_lives", bus.o_Lives, 0);
        chk("rst_score", bus.o_Score, 0);
        chk("rst_level", bus.o_Level, 0);
        chk("rst_move", bus.o_Move_Enable, 0);
        chk("rst_respawn", bus.o_Respawn, 0);
        chk("rst_active", bus.o_Game_Active, 0);
        chk("rst_flash", bus.o_Flash, 0);
        rst_n = 1'b1;

        repeat (3) tick(r);
        chk("idle_ticks_state", bus.o_State, S_IDLE);
        chk("idle_ticks_respawn", r, 0);

        start_game("start");
        repeat (5) @(negedge clk);
        chk("playing_respawn_quiet", bus.o_Respawn, 0);

        die(1'b0, 1'b1, 1'b0);
        goal(1'b0);
        die(1'b1, 1'b0, 1'b1);
        die($urandom_range(0, 1), 1'b0, 1'b0);
        chk("over_state", bus.o_State, S_GAME_OVER);
        repeat (4) tick(r);
        chk("over_hold_state", bus.o_State, S_GAME_OVER);
        chk("over_hold_score", bus.o_Score, m_score);

        start_game("restart");

        for (int g = 0; g < 100; g++) begin
            goal(($urandom_range(0, 9) == 0) || g == 50);
        end
        chk("sat_score", bus.o_Score, 99);
        chk("sat_level", bus.o_Level, 7);

        bus.i_Collided = 1'b1;
        @(negedge clk);
        benign();
        repeat (5) tick(r);
        chk("pre_rst_state", bus.o_State, S_DYING);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_state", bus.o_State, S_IDLE);
        chk("arst_lives", bus.o_Lives, 0);
        chk("arst_score", bus.o_Score, 0);
        chk("arst_level", bus.o_Level, 0);
        chk("arst_flash", bus.o_Flash, 0);
        chk("arst_move", bus.o_Move_Enable, 0);
        chk("arst_active", bus.o_Game_Active, 0);
        chk("arst_respawn", bus.o_Respawn, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        start_game("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
